// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the receive/transmit FSM states.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } uart_state_e;

    // Encoding 2'b11 is treated as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with exact occupancy count; read and write may share a cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_ok, rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign rd_ok = rd_en && !empty;
    // A full FIFO still accepts a write when a word leaves in the same cycle.
    assign wr_ok = wr_en && (!full || rd_ok);

    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with synchroniser, 3-sample majority vote, parity/stop options,
// break detection and an AXI4-Stream receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic [PRESCALE_W-1:0]         prescale,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun_error,
    output logic                          frame_error,
    output logic                          parity_error,
    output logic                          break_detect
);

    localparam int unsigned CW = PRESCALE_W + 3;

    logic rxd_m, rxd_s, rxd_d;
    uart_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, pre_c, t3, t4, t5, t_last;
    logic [PRESCALE_W-1:0] pre_q;
    logic [1:0] par_q;
    logic stop2_q, cfg_load;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [3:0] idx_q, idx_d;
    logic s0_q, s1_q, vote, at_mid;
    logic par_err_q, par_err_d, par_bit_q, par_bit_d, stop_low_q, stop_low_d;
    logic done, any_low, all_low, is_break, wr_req, accept, full, empty;
    logic ovr_d, fe_d, pe_d, brk_d;
    logic [DATA_WIDTH:0] rd_word;

    // Reset high so an idle line does not look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign pre_c  = CW'(pre_q);
    assign t3     = pre_c + (pre_c << 1);
    assign t4     = pre_c << 2;
    assign t5     = t4 + pre_c;
    assign t_last = (pre_c << 3) - CW'(1);
    assign at_mid = (cnt_q == t5);
    assign vote   = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == t_last) ? '0 : cnt_q + CW'(1);
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        par_err_d  = par_err_q;
        par_bit_d  = par_bit_q;
        stop_low_d = stop_low_q;
        cfg_load   = 1'b0;
        done       = 1'b0;
        any_low    = 1'b0;
        all_low    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Edge rather than level: after a break the line must go high first.
                if (!rxd_s && rxd_d) begin
                    state_d    = StStart;
                    cfg_load   = 1'b1;
                    par_err_d  = 1'b0;
                    par_bit_d  = 1'b0;
                    stop_low_d = 1'b0;
                end
            end
            StStart: if (at_mid) begin
                state_d = vote ? StIdle : StData;
                idx_d   = '0;
            end
            StData: if (at_mid) begin
                shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
                idx_d   = idx_q + 4'd1;
                if (idx_q == 4'(DATA_WIDTH - 1))
                    state_d = parity_enabled(par_q) ? StParity : StStop1;
            end
            StParity: if (at_mid) begin
                par_bit_d = vote;
                par_err_d = (^shreg_q) ^ vote ^ (par_q == PAR_ODD);
                state_d   = StStop1;
            end
            StStop1: if (at_mid) begin
                if (stop2_q) begin
                    stop_low_d = !vote;
                    state_d    = StStop2;
                end else begin
                    done    = 1'b1;
                    any_low = !vote;
                    all_low = !vote;
                end
            end
            StStop2: if (at_mid) begin
                done    = 1'b1;
                any_low = stop_low_q | !vote;
                all_low = stop_low_q & !vote;
            end
            default: state_d = StIdle;
        endcase
        if (done) state_d = StIdle;
    end

    assign is_break = all_low && (shreg_q == '0) && !(parity_enabled(par_q) && par_bit_q);
    assign wr_req   = done && !any_low;
    assign accept   = !full || (m_axis_tready && !empty);
    assign brk_d    = done && is_break;
    assign fe_d     = done && any_low;
    assign ovr_d    = wr_req && !accept;
    assign pe_d     = wr_req && accept && par_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pre_q         <= PRESCALE_W'(1);
            par_q         <= PAR_NONE;
            stop2_q       <= 1'b0;
            shreg_q       <= '0;
            idx_q         <= '0;
            s0_q          <= 1'b1;
            s1_q          <= 1'b1;
            par_err_q     <= 1'b0;
            par_bit_q     <= 1'b0;
            stop_low_q    <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            idx_q         <= idx_d;
            par_err_q     <= par_err_d;
            par_bit_q     <= par_bit_d;
            stop_low_q    <= stop_low_d;
            overrun_error <= ovr_d;
            frame_error   <= fe_d;
            parity_error  <= pe_d;
            break_detect  <= brk_d;
            if (cfg_load) begin
                pre_q   <= (prescale == '0) ? PRESCALE_W'(1) : prescale;
                par_q   <= parity_mode;
                stop2_q <= stop_bits;
            end
            if (state_q != StIdle && cnt_q == t3) s0_q <= rxd_s;
            if (state_q != StIdle && cnt_q == t4) s1_q <= rxd_s;
        end
    end

    assign busy = (state_q != StIdle);

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_req),
        .wr_data ({par_err_q, shreg_q}),
        .rd_en   (m_axis_tready),
        .rd_data (rd_word),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
    assign m_axis_tuser  = rd_word[DATA_WIDTH];
    assign m_axis_tvalid = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames driven bit by bit, outputs checked with assertions.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop_bits = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser, m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        overrun_error, frame_error, parity_error, break_detect;

    int vectors = 0;
    int miscompares = 0;
    int n_ovr = 0, n_fe = 0, n_pe = 0, n_brk = 0, n_excl = 0;
    int b_ovr, b_fe, b_pe, b_brk;

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .PRESCALE_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .break_detect  (break_detect)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun_error) n_ovr++;
        if (frame_error)   n_fe++;
        if (parity_error)  n_pe++;
        if (break_detect)  n_brk++;
        if ((int'(overrun_error) + int'(frame_error) + int'(parity_error)) > 1 ||
            (break_detect && !frame_error))
            n_excl++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_ovr = n_ovr; b_fe = n_fe; b_pe = n_pe; b_brk = n_brk;
    endtask

    task automatic slot(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = v;
            @(posedge clk);
            #1;
        end
    endtask

    // par: -1 none, else parity bit value. flip_pos: frame bit whose middle slot is inverted.
    task automatic send_frame(input logic [7:0] d, input int par, input int nstop,
                              input int flip_pos);
        logic [15:0] fr;
        int n;
        fr = '1;
        n = 0;
        fr[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin fr[n] = d[i]; n++; end
        if (par >= 0) begin fr[n] = par[0]; n++; end
        n = n + nstop;
        for (int b = 0; b < n; b++)
            for (int s = 0; s < 8; s++) begin
                rxd = (b == flip_pos && s == 5) ? ~fr[b] : fr[b];
                @(posedge clk);
                #1;
            end
    endtask

    task automatic pop(input string tag, input logic [7:0] d, input logic u);
        check({tag, "_tvalid"}, m_axis_tvalid, 1'b1);
        check({tag, "_tdata"}, m_axis_tdata, d);
        check({tag, "_tuser"}, m_axis_tuser, u);
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {overrun_error, frame_error, parity_error, break_detect}, 0);
        rst = 1'b0;
        slot(1'b1, 8);

        // 1: 8N1 0xA5 with tready=1, exact write latency
        snap();
        m_axis_tready = 1'b1;
        send_frame(8'hA5, -1, 1, -1);
        check("t1_busy_at_decision", busy, 1);
        check("t1_tvalid_before", m_axis_tvalid, 0);
        @(posedge clk);
        #1;
        check("t1_tvalid", m_axis_tvalid, 1);
        check("t1_tdata", m_axis_tdata, 8'hA5);
        check("t1_tuser", m_axis_tuser, 0);
        check("t1_busy_after", busy, 0);
        slot(1'b1, 4);
        m_axis_tready = 1'b0;
        check("t1_count", fifo_count, 0);
        check("t1_no_flags", (n_ovr - b_ovr) + (n_fe - b_fe) + (n_pe - b_pe) + (n_brk - b_brk), 0);

        // 2: 8E1 0x03 good/bad parity, then 8O1 0x03 good parity
        snap();
        parity_mode = 2'b01;
        send_frame(8'h03, 0, 1, -1);
        send_frame(8'h03, 1, 1, -1);
        parity_mode = 2'b10;
        send_frame(8'h03, 1, 1, -1);
        slot(1'b1, 4);
        check("t2_count", fifo_count, 3);
        check("t2_pe_pulses", n_pe - b_pe, 1);
        check("t2_fe_pulses", n_fe - b_fe, 0);
        pop("t2_even_ok", 8'h03, 1'b0);
        pop("t2_even_bad", 8'h03, 1'b1);
        pop("t2_odd_ok", 8'h03, 1'b0);

        // 3: 8N2 overflow with tready=0
        snap();
        parity_mode = 2'b00;
        stop_bits = 1'b1;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), -1, 2, -1);
        slot(1'b1, 4);
        check("t3_count_full", fifo_count, 16);
        check("t3_overrun_pulses", n_ovr - b_ovr, 1);
        check("t3_fe_pulses", n_fe - b_fe, 0);
        for (int i = 0; i < 16; i++) pop($sformatf("t3_word%0d", i), 8'(i), 1'b0);
        check("t3_count_empty", fifo_count, 0);
        check("t3_tvalid_empty", m_axis_tvalid, 0);

        // 4: start-bit glitch rejected; one flipped sample outvoted
        snap();
        stop_bits = 1'b0;
        slot(1'b0, 3);
        slot(1'b1, 20);
        check("t4_glitch_idle", busy, 0);
        check("t4_glitch_count", fifo_count, 0);
        check("t4_glitch_fe", n_fe - b_fe, 0);
        send_frame(8'h96, -1, 1, 3);
        slot(1'b1, 4);
        check("t4_flip_count", fifo_count, 1);
        pop("t4_flip", 8'h96, 1'b0);

        // 5: break held for two frame times, then normal frame
        snap();
        slot(1'b0, 160);
        check("t5_brk_pulses", n_brk - b_brk, 1);
        check("t5_fe_pulses", n_fe - b_fe, 1);
        check("t5_count", fifo_count, 0);
        check("t5_idle_low", busy, 0);
        slot(1'b1, 16);
        send_frame(8'h5A, -1, 1, -1);
        slot(1'b1, 4);
        pop("t5_after_break", 8'h5A, 1'b0);

        // 6: reset mid-DATA with three words queued
        send_frame(8'h11, -1, 1, -1);
        send_frame(8'h22, -1, 1, -1);
        send_frame(8'h33, -1, 1, -1);
        slot(1'b1, 4);
        check("t6_queued", fifo_count, 3);
        slot(1'b0, 8);
        slot(1'b0, 8);
        slot(1'b0, 8);
        slot(1'b1, 5);
        check("t6_busy_mid", busy, 1);
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_tvalid", m_axis_tvalid, 0);
        check("t6_rst_tdata", m_axis_tdata, 0);
        check("t6_rst_flags", {overrun_error, frame_error, parity_error, break_detect}, 0);
        slot(1'b1, 2);
        rst = 1'b0;
        slot(1'b1, 16);
        snap();
        prescale = 16'd0;
        send_frame(8'h3C, -1, 1, -1);
        prescale = 16'd1;
        slot(1'b1, 4);
        check("t6_count_after", fifo_count, 1);
        pop("t6_after_rst", 8'h3C, 1'b0);
        check("t6_no_flags", (n_ovr - b_ovr) + (n_fe - b_fe) + (n_pe - b_pe), 0);
        check("pulse_exclusive", n_excl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
